// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: memory access size encodings, mem_stage FSM states
// and the lane/alignment/extension helpers used by the memory stage.
package pipeline_pkg;

  typedef enum logic [1:0] {
    MEM_SIZE_WORD     = 2'b00,
    MEM_SIZE_HALF     = 2'b01,
    MEM_SIZE_BYTE     = 2'b10,
    MEM_SIZE_WORD_ALT = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    MEM_ST_IDLE,
    MEM_ST_ACCESS,
    MEM_ST_DONE
  } mem_state_e;

  function automatic logic [3:0] mem_lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      MEM_SIZE_HALF: return off[1] ? 4'b1100 : 4'b0011;
      MEM_SIZE_BYTE: return 4'b0001 << off;
      default:       return 4'b1111;
    endcase
  endfunction

  function automatic logic mem_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      MEM_SIZE_HALF: return off[0];
      MEM_SIZE_BYTE: return 1'b0;
      default:       return off != 2'b00;
    endcase
  endfunction

  // Replicate the low bytes so whichever lanes are enabled see the right data.
  function automatic logic [31:0] mem_store_data(input logic [31:0] wd, input logic [1:0] size);
    case (size)
      MEM_SIZE_HALF: return {2{wd[15:0]}};
      MEM_SIZE_BYTE: return {4{wd[7:0]}};
      default:       return wd;
    endcase
  endfunction

  function automatic logic [31:0] mem_load_format(input logic [31:0] word, input logic [1:0] size,
                                                  input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      MEM_SIZE_HALF: return sgn ? {{16{h[15]}}, h} : {16'b0, h};
      MEM_SIZE_BYTE: return sgn ? {{24{b[7]}}, b} : {24'b0, b};
      default:       return word;
    endcase
  endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port data RAM: synchronous byte-enabled write, combinational read, no reset.
module data_ram #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// Multi-cycle pipeline MEM stage: stalls for LATENCY+1 cycles per access, then one DONE cycle.
// Optional sub-word accesses are enabled by defining MEM_STAGE_BYTE_EN.
module mem_stage
  import pipeline_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] aluResult,
  input  logic [31:0] writeData,
  input  logic [4:0]  muxRegFileData,
  input  logic        regWrite,
  input  logic        memToReg,
`ifdef MEM_STAGE_BYTE_EN
  input  logic [1:0]  memSize,
  input  logic        memSigned,
`endif
  output logic [31:0] readData,
  output logic [31:0] outAluResult,
  output logic [4:0]  outmuxRegFileData,
  output logic        outRegWrite,
  output logic        outMemToReg,
  output logic        stall,
  output logic        misalign
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  mem_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              misalign_q, misalign_d;
  logic              store_q, store_d;
  logic              load_q, load_d;
  logic [AW+1:0]     addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;

  logic [1:0]        req_size;
  logic              req_sgn;
  logic              stall_c;
  logic              ram_we;
  logic              acc_mis;
  logic [31:0]       ram_rdata;

`ifdef MEM_STAGE_BYTE_EN
  assign req_size = memSize;
  assign req_sgn  = memSigned;
`else
  assign req_size = MEM_SIZE_WORD;
  assign req_sgn  = 1'b0;
`endif

  assign acc_mis = mem_misaligned(size_q, addr_q[1:0]);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    store_d    = store_q;
    load_d     = load_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    sgn_d      = sgn_q;
    stall_c    = 1'b0;
    ram_we     = 1'b0;

    case (state_q)
      MEM_ST_IDLE: begin
        if (memRead || memWrite) begin
          stall_c = 1'b1;
          store_d = memWrite;
          load_d  = memRead && !memWrite;
          addr_d  = aluResult[AW+1:0];
          wdata_d = writeData;
          size_d  = req_size;
          sgn_d   = req_sgn;
          cnt_d   = CW'(LATENCY - 1);
          state_d = MEM_ST_ACCESS;
        end
      end
      MEM_ST_ACCESS: begin
        stall_c = 1'b1;
        if (cnt_q == '0) begin
          ram_we     = store_q && !acc_mis;
          misalign_d = acc_mis;
          rdata_d    = (load_q && !acc_mis) ?
                       mem_load_format(ram_rdata, size_q, addr_q[1:0], sgn_q) : '0;
          state_d    = MEM_ST_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      MEM_ST_DONE: state_d = MEM_ST_IDLE;
      default:     state_d = MEM_ST_IDLE;
    endcase

    // Reset also suppresses the write strobe so an aborted store never lands.
    if (rst) begin
      state_d    = MEM_ST_IDLE;
      cnt_d      = '0;
      rdata_d    = '0;
      misalign_d = 1'b0;
      stall_c    = 1'b0;
      ram_we     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MEM_ST_IDLE;
      cnt_q      <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
    end
    store_q <= store_d;
    load_q  <= load_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    size_q  <= size_d;
    sgn_q   <= sgn_d;
  end

  data_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (mem_lane_mask(size_q, addr_q[1:0])),
    .addr  (addr_q[AW+1:2]),
    .wdata (mem_store_data(wdata_q, size_q)),
    .rdata (ram_rdata)
  );

  assign stall             = stall_c;
  assign readData          = (state_q == MEM_ST_DONE && !rst) ? rdata_q : '0;
  assign misalign          = (state_q == MEM_ST_DONE && !rst) ? misalign_q : 1'b0;
  assign outAluResult      = aluResult;
  assign outmuxRegFileData = muxRegFileData;
  assign outRegWrite       = regWrite;
  assign outMemToReg       = memToReg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed table-driven bench for mem_stage (DEPTH=256, LATENCY=2), plus reset and passthrough sequences.
module tb_mem_stage;

  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        memRead, memWrite;
  logic [31:0] aluResult, writeData;
  logic [4:0]  muxRegFileData;
  logic        regWrite, memToReg;
  logic [1:0]  memSize;
  logic        memSigned;
  logic [31:0] readData, outAluResult;
  logic [4:0]  outmuxRegFileData;
  logic        outRegWrite, outMemToReg, stall, misalign;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk               (clk),
    .rst               (rst),
    .memRead           (memRead),
    .memWrite          (memWrite),
    .aluResult         (aluResult),
    .writeData         (writeData),
    .muxRegFileData    (muxRegFileData),
    .regWrite          (regWrite),
    .memToReg          (memToReg),
`ifdef MEM_STAGE_BYTE_EN
    .memSize           (memSize),
    .memSigned         (memSigned),
`endif
    .readData          (readData),
    .outAluResult      (outAluResult),
    .outmuxRegFileData (outmuxRegFileData),
    .outRegWrite       (outRegWrite),
    .outMemToReg       (outMemToReg),
    .stall             (stall),
    .misalign          (misalign)
  );

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] exp_rdata;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    memRead = 1'b0; memWrite = 1'b0; aluResult = '0; writeData = '0;
    memSize = 2'b00; memSigned = 1'b0;
  endtask

  // Issue one access from IDLE; inputs are scrambled while stalled to show they are ignored.
  task automatic run_op(input vec_t v);
    int n;
    memRead = v.rd; memWrite = v.wr; aluResult = v.addr; writeData = v.wdata;
    memSize = v.size; memSigned = v.sgn;
    n = 0;
    @(negedge clk);
    while (stall === 1'b1 && n < 20) begin
      n++;
      @(posedge clk); #1;
      aluResult = ~v.addr; writeData = ~v.wdata;
      @(negedge clk);
    end
    check({v.name, " stall_cycles"}, 32'(n), 32'(LATENCY + 1));
    check({v.name, " readData"}, readData, v.exp_rdata);
    check({v.name, " misalign"}, {31'b0, misalign}, {31'b0, v.exp_mis});
    @(posedge clk); #1;
    drive_idle();
  endtask

  function automatic vec_t mk(input string name, input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] size, input logic sgn,
                              input logic [31:0] exp_rdata, input logic exp_mis);
    vec_t v;
    v.name = name; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.size = size; v.sgn = sgn; v.exp_rdata = exp_rdata; v.exp_mis = exp_mis;
    return v;
  endfunction

  initial begin
    vecs.push_back(mk("st_10",        0, 1, 32'h10, 32'hDEADBEEF, 2'b00, 0, 32'h0,        0));
    vecs.push_back(mk("ld_10",        1, 0, 32'h10, 32'h0,        2'b00, 0, 32'hDEADBEEF, 0));
    vecs.push_back(mk("ld_12_mis",    1, 0, 32'h12, 32'h0,        2'b00, 0, 32'h0,        1));
    vecs.push_back(mk("ld_10_again",  1, 0, 32'h10, 32'h0,        2'b00, 0, 32'hDEADBEEF, 0));
    vecs.push_back(mk("st_12_mis",    0, 1, 32'h12, 32'h12345678, 2'b00, 0, 32'h0,        1));
    vecs.push_back(mk("ld_10_nowr",   1, 0, 32'h10, 32'h0,        2'b00, 0, 32'hDEADBEEF, 0));
    vecs.push_back(mk("rdwr_14",      1, 1, 32'h14, 32'hCAFEF00D, 2'b00, 0, 32'h0,        0));
    vecs.push_back(mk("ld_14",        1, 0, 32'h14, 32'h0,        2'b00, 0, 32'hCAFEF00D, 0));
    vecs.push_back(mk("st_alias",     0, 1, 32'(DEPTH*4+8), 32'h11112222, 2'b00, 0, 32'h0, 0));
    vecs.push_back(mk("ld_08",        1, 0, 32'h08, 32'h0,        2'b00, 0, 32'h11112222, 0));
    vecs.push_back(mk("ld_alias",     1, 0, 32'(DEPTH*4+8), 32'h0, 2'b00, 0, 32'h11112222, 0));
    vecs.push_back(mk("st_20",        0, 1, 32'h20, 32'h00000007, 2'b00, 0, 32'h0,        0));
    vecs.push_back(mk("ld_20",        1, 0, 32'h20, 32'h0,        2'b00, 0, 32'h00000007, 0));
`ifdef MEM_STAGE_BYTE_EN
    vecs.push_back(mk("st_w0",        0, 1, 32'h00, 32'h00000000, 2'b00, 0, 32'h0,        0));
    vecs.push_back(mk("sb_03",        0, 1, 32'h03, 32'h00000080, 2'b10, 0, 32'h0,        0));
    vecs.push_back(mk("lb_03_s",      1, 0, 32'h03, 32'h0,        2'b10, 1, 32'hFFFFFF80, 0));
    vecs.push_back(mk("lb_03_u",      1, 0, 32'h03, 32'h0,        2'b10, 0, 32'h00000080, 0));
    vecs.push_back(mk("lw_00",        1, 0, 32'h00, 32'h0,        2'b00, 0, 32'h80000000, 0));
    vecs.push_back(mk("sh_02",        0, 1, 32'h02, 32'hAAAA8001, 2'b01, 0, 32'h0,        0));
    vecs.push_back(mk("lh_02_s",      1, 0, 32'h02, 32'h0,        2'b01, 1, 32'hFFFF8001, 0));
    vecs.push_back(mk("lh_01_mis",    1, 0, 32'h01, 32'h0,        2'b01, 0, 32'h0,        1));
    vecs.push_back(mk("sh_01_mis",    0, 1, 32'h01, 32'h0000FFFF, 2'b01, 0, 32'h0,        1));
    vecs.push_back(mk("lw_00_final",  1, 0, 32'h00, 32'h0,        2'b00, 0, 32'h80010000, 0));
`endif

    // Reset with a pending request: outputs stay quiet.
    drive_idle();
    muxRegFileData = '0; regWrite = 1'b0; memToReg = 1'b0;
    rst = 1'b1; memRead = 1'b1;
    @(posedge clk); #1;
    check("rst stall", {31'b0, stall}, 32'h0);
    check("rst readData", readData, 32'h0);
    check("rst misalign", {31'b0, misalign}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; drive_idle();
    #1;
    check("post_rst stall", {31'b0, stall}, 32'h0);
    check("post_rst readData", readData, 32'h0);

    // Non-memory op: passthrough, no stall.
    aluResult = 32'h55; regWrite = 1'b1; memToReg = 1'b0; muxRegFileData = 5'h1A;
    #1;
    check("nomem stall", {31'b0, stall}, 32'h0);
    check("nomem outAluResult", outAluResult, 32'h55);
    check("nomem outRegWrite", {31'b0, outRegWrite}, 32'h1);
    check("nomem outMemToReg", {31'b0, outMemToReg}, 32'h0);
    check("nomem outmux", {27'b0, outmuxRegFileData}, 32'h1A);
    check("nomem readData", readData, 32'h0);
    @(posedge clk); #1;
    check("nomem stall_next", {31'b0, stall}, 32'h0);
    drive_idle(); regWrite = 1'b0; muxRegFileData = '0;

    foreach (vecs[i]) run_op(vecs[i]);

    // Reset during the second ACCESS cycle of a store to 0x20 aborts the write.
    memWrite = 1'b1; aluResult = 32'h20; writeData = 32'h1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort in_access stall", {31'b0, stall}, 32'h1);
    rst = 1'b1;
    #1;
    check("abort during_rst stall", {31'b0, stall}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; drive_idle();
    #1;
    check("abort after stall", {31'b0, stall}, 32'h0);
    check("abort after readData", readData, 32'h0);
    check("abort after misalign", {31'b0, misalign}, 32'h0);
    run_op(mk("ld_20_after_abort", 1, 0, 32'h20, 32'h0, 2'b00, 0, 32'h00000007, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
